// File: rtl/mcpu_core_intctl.sv
// mcpu_core_intctl: eight-source edge-latched interrupt controller with a CSR map and a REQ/SERVICE handshake.
// Defining MCPU_INTCTL_TIMER_EN adds a compare timer that owns pend[7].
module mcpu_core_intctl (
  input  logic        clkrst_core_clk,
  input  logic        clkrst_core_rst_n,
  input  logic [7:0]  irq_in,
  input  logic        interrupts_enabled,
  input  logic        int_ack,
  input  logic        eret_inst,
  input  logic        csr_we,
  input  logic [1:0]  csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        int_req,
  output logic [3:0]  int_type
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_TCMP = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic [3:0]  int_type_reg, int_type_next;
  logic [7:0]  irq_q_reg;
  logic [7:0]  pend_reg, pend_next;
  logic [7:0]  mask_reg;
  logic [7:0]  edge_set, w1c_clr, ack_clr, active;
  logic [2:0]  sel;
  logic [31:0] tcmp_rd, tcnt_rd;

  assign w1c_clr = (csr_we && csr_addr == A_PEND) ? csr_wdata[7:0] : 8'h00;
  assign active  = pend_reg & mask_reg;

`ifdef MCPU_INTCTL_TIMER_EN
  logic [31:0] tcmp_reg, tcnt_reg;
  logic        timer_hit;
  logic        unused_irq7;

  // Source 7 belongs to the timer; the external line is still sampled but never used.
  assign unused_irq7 = irq_in[7] ^ irq_q_reg[7];
  assign timer_hit   = (tcmp_reg != 32'd0) && (tcnt_reg == tcmp_reg);
  assign edge_set    = {timer_hit, irq_in[6:0] & ~irq_q_reg[6:0]};

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      tcmp_reg <= 32'd0;
      tcnt_reg <= 32'd0;
    end else if (csr_we && csr_addr == A_TCMP) begin
      tcmp_reg <= csr_wdata;
      tcnt_reg <= 32'd0;
    end else if (timer_hit) begin
      tcnt_reg <= 32'd0;
    end else if (tcmp_reg != 32'd0) begin
      tcnt_reg <= tcnt_reg + 32'd1;
    end
  end

  assign tcmp_rd = tcmp_reg;
  assign tcnt_rd = tcnt_reg;
`else
  logic unused_wdata;

  assign unused_wdata = ^csr_wdata[31:8];
  assign edge_set     = irq_in & ~irq_q_reg;
  assign tcmp_rd      = 32'd0;
  assign tcnt_rd      = 32'd0;
`endif

  // A rising edge wins over any clear of the same bit in the same cycle.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pend
      assign ack_clr[gi]   = (state_reg == ST_REQ) && int_ack && (int_type_reg[2:0] == 3'(gi));
      assign pend_next[gi] = edge_set[gi] | (pend_reg[gi] & ~(w1c_clr[gi] | ack_clr[gi]));
    end
  endgenerate

  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) sel = 3'(i);
    end
  end

  always_comb begin
    state_next    = state_reg;
    int_type_next = int_type_reg;
    case (state_reg)
      ST_IDLE: begin
        int_type_next = 4'h0;
        if (interrupts_enabled && (|active)) begin
          state_next    = ST_REQ;
          int_type_next = {1'b1, sel};
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          state_next = ST_SERVICE;
        end else if (!interrupts_enabled || !active[int_type_reg[2:0]]) begin
          state_next    = ST_IDLE;
          int_type_next = 4'h0;
        end
      end
      ST_SERVICE: begin
        if (eret_inst) begin
          state_next    = ST_IDLE;
          int_type_next = 4'h0;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        int_type_next = 4'h0;
      end
    endcase
  end

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      state_reg    <= ST_IDLE;
      int_type_reg <= 4'h0;
      irq_q_reg    <= 8'h00;
      pend_reg     <= 8'h00;
      mask_reg     <= 8'h00;
    end else begin
      state_reg    <= state_next;
      int_type_reg <= int_type_next;
      irq_q_reg    <= irq_in;
      pend_reg     <= pend_next;
      if (csr_we && csr_addr == A_MASK) mask_reg <= csr_wdata[7:0];
    end
  end

  always_comb begin
    case (csr_addr)
      A_PEND:  csr_rdata = {24'h0, pend_reg};
      A_MASK:  csr_rdata = {24'h0, mask_reg};
      A_TCMP:  csr_rdata = tcmp_rd;
      default: csr_rdata = tcnt_rd;
    endcase
  end

  assign int_req  = (state_reg == ST_REQ);
  assign int_type = int_type_reg;

endmodule
